// File: rtl/quad_gray_decoder.sv
// Quadrature (gray-code) encoder decoder: synchronise, debounce, decode +/-1 gray
// steps and divide them into detents to produce a wrapping position count.
module quad_gray_decoder #(
  parameter int BITS     = 8,
  parameter int DEB_LOG2 = 4,
  parameter int DETENT   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enc_a,
  input  logic            enc_b,
  input  logic            clr,
  output logic [BITS-1:0] pos,
  output logic            step,
  output logic            dir,
  output logic            err
);

  localparam int ARM_W = DEB_LOG2 + 2;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'((1 << DEB_LOG2) + 3);
  localparam logic [DEB_LOG2-1:0] CNT_MAX = '1;
  localparam logic signed [2:0] SUB_MAX = 3'(DETENT - 1);

  logic                a_meta, s_a, b_meta, s_b;
  logic                f_a, f_b;
  logic [DEB_LOG2-1:0] cnt_a, cnt_b;
  logic [1:0]          prev;
  logic [1:0]          idx;
  logic [1:0]          delta;
  logic signed [2:0]   sub;
  logic [ARM_W-1:0]    arm_cnt;
  logic                armed;

  assign idx   = {f_a, f_a ^ f_b};
  assign delta = idx - prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_meta <= 1'b0;
      s_a    <= 1'b0;
      b_meta <= 1'b0;
      s_b    <= 1'b0;
    end else begin
      a_meta <= enc_a;
      s_a    <= a_meta;
      b_meta <= enc_b;
      s_b    <= b_meta;
    end
  end

  // A filtered bit only follows its pin after 2^DEB_LOG2 consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_a   <= 1'b0;
      cnt_a <= '0;
      f_b   <= 1'b0;
      cnt_b <= '0;
    end else begin
      if (s_a == f_a) begin
        cnt_a <= '0;
      end else if (cnt_a == CNT_MAX) begin
        f_a   <= s_a;
        cnt_a <= '0;
      end else begin
        cnt_a <= cnt_a + DEB_LOG2'(1);
      end

      if (s_b == f_b) begin
        cnt_b <= '0;
      end else if (cnt_b == CNT_MAX) begin
        f_b   <= s_b;
        cnt_b <= '0;
      end else begin
        cnt_b <= cnt_b + DEB_LOG2'(1);
      end
    end
  end

  // Hold off decoding until the filters have settled onto the encoder's rest state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt <= '0;
      armed   <= 1'b0;
    end else if (!armed) begin
      if (arm_cnt == ARM_LAST) armed <= 1'b1;
      arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 2'd0;
      sub  <= '0;
      pos  <= '0;
      step <= 1'b0;
      dir  <= 1'b1;
      err  <= 1'b0;
    end else begin
      prev <= idx;
      step <= 1'b0;
      if (clr) begin
        pos <= '0;
        sub <= '0;
        err <= 1'b0;
      end else if (armed) begin
        case (delta)
          2'd1: begin
            if (sub == SUB_MAX) begin
              pos  <= pos + BITS'(1);
              sub  <= '0;
              step <= 1'b1;
              dir  <= 1'b1;
            end else begin
              sub <= sub + 3'sd1;
            end
          end
          2'd3: begin
            if (sub == -SUB_MAX) begin
              pos  <= pos - BITS'(1);
              sub  <= '0;
              step <= 1'b1;
              dir  <= 1'b0;
            end else begin
              sub <= sub - 3'sd1;
            end
          end
          2'd2:    err <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_quad_gray_decoder.sv
// Directed bench for quad_gray_decoder: one DETENT=4 and one DETENT=1 instance,
// both with DEB_LOG2=2 so a clean pin change is held for 8 cycles.
module tb_quad_gray_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enc_a4, enc_b4, clr4;
  logic       enc_a1, enc_b1, clr1;
  logic [7:0] pos4, pos1;
  logic       step4, dir4, err4;
  logic       step1, dir1, err1;

  int vec  = 0;
  int miss = 0;
  int pulses4 = 0;
  int pulses1 = 0;
  int base;

  always #5 clk = ~clk;

  quad_gray_decoder #(.BITS(8), .DEB_LOG2(2), .DETENT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a4), .enc_b(enc_b4), .clr(clr4),
    .pos(pos4), .step(step4), .dir(dir4), .err(err4)
  );

  quad_gray_decoder #(.BITS(8), .DEB_LOG2(2), .DETENT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a1), .enc_b(enc_b1), .clr(clr1),
    .pos(pos1), .step(step1), .dir(dir1), .err(err1)
  );

  // Pulse counters sample on the rising edge, before the registered step updates.
  always @(posedge clk) begin
    if (step4) pulses4++;
    if (step1) pulses1++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive a DETENT=4 pin pair at a falling edge; optionally check the 7-cycle pulse latency.
  task automatic drive4(input logic a, input logic b, input bit completes);
    enc_a4 = a;
    enc_b4 = b;
    if (completes) begin
      repeat (6) @(negedge clk);
      vec++;
      if (step4 !== 1'b0) begin miss++; $display("[TB] FAIL latency_early: got %b, expected 0", step4); end
      @(negedge clk);
      vec++;
      if (step4 !== 1'b1) begin miss++; $display("[TB] FAIL latency_pulse: got %b, expected 1", step4); end
      @(negedge clk);
      vec++;
      if (step4 !== 1'b0) begin miss++; $display("[TB] FAIL pulse_width: got %b, expected 0", step4); end
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic drive1(input logic a, input logic b);
    enc_a1 = a;
    enc_b1 = b;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enc_a4 = 1'b1; enc_b4 = 1'b1;
    enc_a1 = 1'b1; enc_b1 = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (pos4 !== 8'd0) begin miss++; $display("[TB] FAIL rst_pos: got %0d, expected 0", pos4); end
    vec++;
    if (dir4 !== 1'b1) begin miss++; $display("[TB] FAIL rst_dir: got %b, expected 1", dir4); end
    vec++;
    if (err4 !== 1'b0 || step4 !== 1'b0) begin
      miss++; $display("[TB] FAIL rst_err_step: got err=%b step=%b, expected 0 0", err4, step4);
    end
    base = pulses4;
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vec++;
    if (pos4 !== 8'd0) begin miss++; $display("[TB] FAIL arm_pos: got %0d, expected 0", pos4); end
    vec++;
    if (err4 !== 1'b0) begin miss++; $display("[TB] FAIL arm_err: got %b, expected 0", err4); end
    vec++;
    if (err1 !== 1'b0) begin miss++; $display("[TB] FAIL arm_err1: got %b, expected 0", err1); end
    vec++;
    if (dir4 !== 1'b1) begin miss++; $display("[TB] FAIL arm_dir: got %b, expected 1", dir4); end
    vec++;
    if (pulses4 - base !== 0) begin miss++; $display("[TB] FAIL arm_step: got %0d pulses, expected 0", pulses4 - base); end
    // Restart from a 00 rest state for the remaining scenarios.
    rst_n = 1'b0;
    enc_a4 = 1'b0; enc_b4 = 1'b0;
    enc_a1 = 1'b0; enc_b1 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    vec++;
    if (pos4 !== 8'd0 || err4 !== 1'b0) begin
      miss++; $display("[TB] FAIL rerst: got pos=%0d err=%b, expected 0 0", pos4, err4);
    end
  endtask

  task automatic test_forward;
    base = pulses4;
    for (int r = 0; r < 2; r++) begin
      drive4(1'b0, 1'b1, 1'b0);
      drive4(1'b1, 1'b1, 1'b0);
      drive4(1'b1, 1'b0, 1'b0);
      drive4(1'b0, 1'b0, 1'b1);
    end
    vec++;
    if (pos4 !== 8'd2) begin miss++; $display("[TB] FAIL fwd_pos: got %0d, expected 2", pos4); end
    vec++;
    if (dir4 !== 1'b1) begin miss++; $display("[TB] FAIL fwd_dir: got %b, expected 1", dir4); end
    vec++;
    if (pulses4 - base !== 2) begin miss++; $display("[TB] FAIL fwd_pulses: got %0d, expected 2", pulses4 - base); end
    vec++;
    if (err4 !== 1'b0) begin miss++; $display("[TB] FAIL fwd_err: got %b, expected 0", err4); end
  endtask

  task automatic test_reverse_wrap;
    base = pulses1;
    drive1(1'b1, 1'b0);
    vec++;
    if (pos1 !== 8'd255) begin miss++; $display("[TB] FAIL wrap_down_pos: got %0d, expected 255", pos1); end
    vec++;
    if (dir1 !== 1'b0) begin miss++; $display("[TB] FAIL wrap_down_dir: got %b, expected 0", dir1); end
    vec++;
    if (pulses1 - base !== 1) begin miss++; $display("[TB] FAIL wrap_down_pulses: got %0d, expected 1", pulses1 - base); end
    vec++;
    if (err1 !== 1'b0) begin miss++; $display("[TB] FAIL wrap_down_err: got %b, expected 0", err1); end
    drive1(1'b0, 1'b0);
    vec++;
    if (pos1 !== 8'd0 || dir1 !== 1'b1) begin
      miss++; $display("[TB] FAIL wrap_up: got pos=%0d dir=%b, expected 0 1", pos1, dir1);
    end
  endtask

  task automatic test_bounce;
    base = pulses4;
    for (int i = 0; i < 12; i++) begin
      enc_a4 = ~enc_a4;
      @(negedge clk);
    end
    enc_a4 = 1'b0;
    repeat (8) @(negedge clk);
    enc_b4 = 1'b1;
    repeat (3) @(negedge clk);
    enc_b4 = 1'b0;
    repeat (10) @(negedge clk);
    vec++;
    if (pos4 !== 8'd2) begin miss++; $display("[TB] FAIL bounce_pos: got %0d, expected 2", pos4); end
    vec++;
    if (err4 !== 1'b0) begin miss++; $display("[TB] FAIL bounce_err: got %b, expected 0", err4); end
    vec++;
    if (pulses4 - base !== 0) begin miss++; $display("[TB] FAIL bounce_step: got %0d pulses, expected 0", pulses4 - base); end
  endtask

  task automatic test_illegal;
    drive1(1'b1, 1'b1);
    vec++;
    if (err1 !== 1'b1) begin miss++; $display("[TB] FAIL illegal_err: got %b, expected 1", err1); end
    vec++;
    if (pos1 !== 8'd0) begin miss++; $display("[TB] FAIL illegal_pos: got %0d, expected 0", pos1); end
    drive1(1'b1, 1'b0);
    drive1(1'b0, 1'b0);
    drive1(1'b0, 1'b1);
    vec++;
    if (pos1 !== 8'd3) begin miss++; $display("[TB] FAIL after_err_pos: got %0d, expected 3", pos1); end
    vec++;
    if (err1 !== 1'b1) begin miss++; $display("[TB] FAIL err_sticky: got %b, expected 1", err1); end
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    vec++;
    if (pos1 !== 8'd0 || err1 !== 1'b0) begin
      miss++; $display("[TB] FAIL clr1: got pos=%0d err=%b, expected 0 0", pos1, err1);
    end
  endtask

  task automatic test_mid_detent_clr;
    base = pulses4;
    drive4(1'b0, 1'b1, 1'b0);
    drive4(1'b1, 1'b1, 1'b0);
    drive4(1'b0, 1'b1, 1'b0);
    drive4(1'b0, 1'b0, 1'b0);
    vec++;
    if (pos4 !== 8'd2 || pulses4 - base !== 0) begin
      miss++; $display("[TB] FAIL reversal: got pos=%0d pulses=%0d, expected 2 0", pos4, pulses4 - base);
    end
    drive4(1'b0, 1'b1, 1'b0);
    drive4(1'b1, 1'b1, 1'b0);
    drive4(1'b1, 1'b0, 1'b0);
    vec++;
    if (pos4 !== 8'd2 || pulses4 - base !== 0) begin
      miss++; $display("[TB] FAIL pre_collision: got pos=%0d pulses=%0d, expected 2 0", pos4, pulses4 - base);
    end
    // The completing step decodes on the 7th rising edge; clr is high for exactly that edge.
    enc_a4 = 1'b0;
    enc_b4 = 1'b0;
    repeat (6) @(negedge clk);
    clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
    vec++;
    if (pos4 !== 8'd0) begin miss++; $display("[TB] FAIL collision_pos: got %0d, expected 0", pos4); end
    vec++;
    if (step4 !== 1'b0) begin miss++; $display("[TB] FAIL collision_step: got %b, expected 0", step4); end
    repeat (2) @(negedge clk);
    vec++;
    if (pulses4 - base !== 0) begin miss++; $display("[TB] FAIL collision_pulses: got %0d, expected 0", pulses4 - base); end
    drive4(1'b0, 1'b1, 1'b0);
    drive4(1'b1, 1'b1, 1'b0);
    drive4(1'b1, 1'b0, 1'b0);
    drive4(1'b0, 1'b0, 1'b1);
    vec++;
    if (pos4 !== 8'd1 || dir4 !== 1'b1) begin
      miss++; $display("[TB] FAIL post_clr_detent: got pos=%0d dir=%b, expected 1 1", pos4, dir4);
    end
    vec++;
    if (pulses4 - base !== 1) begin miss++; $display("[TB] FAIL post_clr_pulses: got %0d, expected 1", pulses4 - base); end
    vec++;
    if (err4 !== 1'b0) begin miss++; $display("[TB] FAIL post_clr_err: got %b, expected 0", err4); end
  endtask

  initial begin
    rst_n  = 1'b0;
    clr4   = 1'b0;
    clr1   = 1'b0;
    enc_a4 = 1'b0; enc_b4 = 1'b0;
    enc_a1 = 1'b0; enc_b1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_bounce();
    test_illegal();
    test_mid_detent_clr();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
